// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_mp register file and its clear sequencer.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int rd_addr_lsb(input int k, input int addr_w);
    return k * addr_w;
  endfunction

  function automatic int rd_data_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on request, and
// owns the ready flag and the registered dropped-write pulse.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req_i,
  input  logic              wr_en_i,
  output logic              ready_o,
  output logic              wr_ignored_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              wr_ignored_q, wr_ignored_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wr_ignored_d = wr_en_i && ((state_q != RF_IDLE) || clear_req_i);
    case (state_q)
      RF_IDLE: begin
        if (clear_req_i) begin
          state_d   = RF_CLEAR;
          clr_cnt_d = '0;
        end
      end
      RF_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = RF_IDLE;
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RF_CLEAR;
      clr_cnt_q    <= '0;
      wr_ignored_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ignored_q <= wr_ignored_d;
    end
  end

  assign ready_o      = (state_q == RF_IDLE);
  assign wr_ignored_o = wr_ignored_q;
  assign clr_we_o     = (state_q == RF_CLEAR);
  assign clr_addr_o   = clr_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardware clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ignored,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;
  logic [DATA_W-1:0] mem_q [DEPTH];

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clock        (clock),
    .reset        (reset),
    .clear_req_i  (clear_req),
    .wr_en_i      (wr_en),
    .ready_o      (ready),
    .wr_ignored_o (wr_ignored),
    .clr_we_o     (clr_we),
    .clr_addr_o   (clr_addr)
  );

  assign user_we = wr_en && ready && !clear_req && !(ZERO_REG && (wr_addr == '0));

  // NOTE: the array has no reset; the clear sweep zeroes it before ready rises.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (user_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;

    assign addr = rd_addr[rd_addr_lsb(k, ADDR_W) +: ADDR_W];

    always_comb begin
      word = mem_q[addr];
      if (ZERO_REG && (addr == '0)) word = '0;
`ifdef REGFILE_BYPASS_EN
      if (user_we && (wr_addr == addr)) word = wr_data;
`else
`endif
      if (!ready) word = '0;
    end

    assign rd_data[rd_data_lsb(k, DATA_W) +: DATA_W] = word;
  end

endmodule
